// File: rtl/pattern_classifier_pkg.sv
// Shared types and helpers for the pattern classifier.
// Holds the default-width rule record and the rule-index width function.
package pattern_classifier_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CODE_W_DEF = 3;

    typedef struct packed {
        logic                  en;
        logic [DATA_W_DEF-1:0] mask;
        logic [DATA_W_DEF-1:0] value;
        logic [CODE_W_DEF-1:0] code;
    } rule_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pattern_rule_match.sv
// Single-rule masked comparator, purely combinational.
// Mask bit 1 = compared, 0 = don't care; a disabled rule never matches.
module pattern_rule_match #(
    parameter int DATA_W = 4
) (
    input  logic              en_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_o
);

    assign match_o = en_i && (((data_i ^ value_i) & mask_i) == '0);

endmodule

// File: rtl/pattern_classifier.sv
// Registered first-match classifier with valid/ready handshake.
// Optional hit counters: define PATTERN_CLASSIFIER_HIT_CNT_EN.
module pattern_classifier
    import pattern_classifier_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CODE_W       = 3,
    parameter int NUM_RULES    = 4,
    parameter int DEFAULT_CODE = 5,
    parameter int CNT_W        = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_we,
    input  logic [idx_w(NUM_RULES)-1:0]        cfg_idx,
    input  logic                               cfg_en,
    input  logic [DATA_W-1:0]                  cfg_mask,
    input  logic [DATA_W-1:0]                  cfg_value,
    input  logic [CODE_W-1:0]                  cfg_code,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CODE_W-1:0]                  out_code,
    output logic                               out_hit,
    output logic [idx_w(NUM_RULES)-1:0]        out_rule,
    input  logic [$clog2(NUM_RULES+1)-1:0]     cnt_idx,
    input  logic                               cnt_clr,
    output logic [CNT_W-1:0]                   cnt_data
);

    localparam int IW = idx_w(NUM_RULES);
    localparam int CW = $clog2(NUM_RULES + 1);
    localparam logic [CODE_W-1:0] DEF_CODE = CODE_W'(DEFAULT_CODE);

    logic [NUM_RULES-1:0] rule_en_q, rule_en_d;
    logic [DATA_W-1:0]    rule_mask_q  [NUM_RULES];
    logic [DATA_W-1:0]    rule_mask_d  [NUM_RULES];
    logic [DATA_W-1:0]    rule_value_q [NUM_RULES];
    logic [DATA_W-1:0]    rule_value_d [NUM_RULES];
    logic [CODE_W-1:0]    rule_code_q  [NUM_RULES];
    logic [CODE_W-1:0]    rule_code_d  [NUM_RULES];

    logic [NUM_RULES-1:0] match;
    logic                 win_hit;
    logic [IW-1:0]        win_idx;
    logic [CODE_W-1:0]    win_code;

    logic                 out_valid_q, out_valid_d;
    logic [CODE_W-1:0]    out_code_q, out_code_d;
    logic                 out_hit_q, out_hit_d;
    logic [IW-1:0]        out_rule_q, out_rule_d;

    logic                 accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Rule table write; indices beyond the table match no entry and are dropped
    always_comb begin
        rule_en_d    = rule_en_q;
        rule_mask_d  = rule_mask_q;
        rule_value_d = rule_value_q;
        rule_code_d  = rule_code_q;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (cfg_we && cfg_idx == IW'(i)) begin
                rule_en_d[i]    = cfg_en;
                rule_mask_d[i]  = cfg_mask;
                rule_value_d[i] = cfg_value;
                rule_code_d[i]  = cfg_code;
            end
        end
    end

    // Rule table storage
    always_ff @(posedge clk) begin
        if (rst) begin
            rule_en_q <= '0;
            for (int i = 0; i < NUM_RULES; i++) begin
                rule_mask_q[i]  <= '0;
                rule_value_q[i] <= '0;
                rule_code_q[i]  <= '0;
            end
        end else begin
            rule_en_q    <= rule_en_d;
            rule_mask_q  <= rule_mask_d;
            rule_value_q <= rule_value_d;
            rule_code_q  <= rule_code_d;
        end
    end

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
        pattern_rule_match #(
            .DATA_W (DATA_W)
        ) u_match (
            .en_i    (rule_en_q[g]),
            .mask_i  (rule_mask_q[g]),
            .value_i (rule_value_q[g]),
            .data_i  (in_data),
            .match_o (match[g])
        );
    end

    // Priority encoder: scanning downward lets the lowest index win
    always_comb begin
        win_hit  = 1'b0;
        win_idx  = '0;
        win_code = DEF_CODE;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_hit  = 1'b1;
                win_idx  = IW'(i);
                win_code = rule_code_q[i];
            end
        end
    end

    // Output register next state: load on accept, retire on consume, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_hit_d   = out_hit_q;
        out_rule_d  = out_rule_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_code_d  = win_code;
            out_hit_d   = win_hit;
            out_rule_d  = win_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_hit_q   <= 1'b0;
            out_rule_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_hit_q   <= out_hit_d;
            out_rule_q  <= out_rule_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_hit   = out_hit_q;
    assign out_rule  = out_rule_q;

`ifdef PATTERN_CLASSIFIER_HIT_CNT_EN

    logic [CNT_W-1:0] cnt_q [NUM_RULES+1];
    logic [CNT_W-1:0] cnt_d [NUM_RULES+1];
    logic [CW-1:0]    win_slot;
    logic [CNT_W-1:0] cnt_rd;

    // Slot NUM_RULES is the miss counter
    assign win_slot = win_hit ? CW'(win_idx) : CW'(NUM_RULES);

    // Counter update: clear beats increment; saturate at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            for (int i = 0; i <= NUM_RULES; i++) begin
                cnt_d[i] = '0;
            end
        end else if (accept) begin
            for (int i = 0; i <= NUM_RULES; i++) begin
                if (win_slot == CW'(i) && cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_RULES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter read mux; out-of-range selects read as zero
    always_comb begin
        cnt_rd = '0;
        for (int i = 0; i <= NUM_RULES; i++) begin
            if (cnt_idx == CW'(i)) begin
                cnt_rd = cnt_q[i];
            end
        end
    end

    assign cnt_data = cnt_rd;

`else

    logic unused_cnt;

    assign unused_cnt = ^{cnt_idx, cnt_clr};
    assign cnt_data   = '0;

`endif

endmodule

// File: doc/pattern_classifier.md
# pattern_classifier

Registered, programmable first-match pattern classifier with a valid/ready stream interface. Each input word is compared against a table of NUM_RULES mask/value rules. The lowest-index enabled matching rule supplies the output code; an unmatched word gets DEFAULT_CODE. It sits between a data source and a downstream consumer that needs a small class code per word, and it replaces fixed `casex` decoders with a run-time-programmable, back-pressurable version.

## Interface
Parameters:
- DATA_W, 4, input word width
- CODE_W, 3, output code width
- NUM_RULES, 4, number of rule entries (>=1)
- DEFAULT_CODE, 5, code emitted when no rule matches
- CNT_W, 16, hit-counter width (used only with PATTERN_CLASSIFIER_HIT_CNT_EN)

Ports (IW = max(1, $clog2(NUM_RULES)); CW = $clog2(NUM_RULES+1)):
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  rule write strobe
- cfg_idx  in  IW  rule index to write
- cfg_en  in  1  rule enable
- cfg_mask  in  DATA_W  compare mask; 1 = bit compared, 0 = don't care
- cfg_value  in  DATA_W  compare value
- cfg_code  in  CODE_W  code emitted on match
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- in_data  in  DATA_W  input word
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_code  out  CODE_W  classified code
- out_hit  out  1  1 = some rule matched; 0 = default path
- out_rule  out  IW  matching rule index (0 when out_hit = 0)
- cnt_idx  in  CW  counter select; NUM_RULES selects the miss counter (macro only)
- cnt_clr  in  1  clear all counters (macro only)
- cnt_data  out  CNT_W  selected counter value, combinational read (macro only)

## Operation
- Reset clears all rules (en=0, mask=0, value=0, code=0), out_valid=0, out_code=0, out_hit=0, out_rule=0, and all counters.
- Rule i matches when en_i=1 and ((in_data ^ value_i) & mask_i) == 0.
- Priority is the lowest matching index. An enabled rule with mask=0 matches every word.
- No match: out_code=DEFAULT_CODE (truncated to CODE_W), out_hit=0, out_rule=0.
- Acceptance occurs when in_valid && in_ready. On acceptance, the result is loaded into the output register.
- in_ready = !out_valid || out_ready. This gives full throughput with no bubble.
- Output holds stable while out_valid && !out_ready.
- If cfg_we is asserted in the same cycle as an acceptance, the word is classified against the pre-write table. The new rule applies from the next cycle.
- cfg_idx >= NUM_RULES: the write is ignored.
- Reset mid-stream: any pending output is dropped, and the table is cleared.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 word/cycle when out_ready=1.
- A rule write is visible to classification 1 cycle after cfg_we.
- Counter increment is visible on cnt_data the cycle after acceptance. cnt_clr takes effect next cycle and has priority over a simultaneous increment.

## Configuration
- PATTERN_CLASSIFIER_HIT_CNT_EN defined: the block adds NUM_RULES+1 saturating counters (one per rule plus one miss counter).
  - On acceptance, the counter for the winning rule (or the miss counter) increments by 1 and saturates at all-ones.
  - cnt_idx > NUM_RULES reads 0.
- Not defined: there are no counter registers. cnt_data is tied to 0, and cnt_idx and cnt_clr are ignored.

## Structure
- Package pattern_classifier_pkg holds:
  - the rule struct type (en, mask, value, code), parameterised through the package's default widths;
  - a function computing the IW index width.
- Sub-module pattern_rule_match is a purely combinational single-rule comparator, instantiated NUM_RULES times. The priority encoder and registers stay in the top.

## Test plan
- Default path after reset: rst then in_data=4'b0110, out_ready=1 -> out_code=5, out_hit=0 one cycle after acceptance.
- Casex-equivalent table: program rules 0..3 with mask=4'b1100, values 0000/0100/1000/1100, codes 1..4; stream 0..15 -> codes 1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4 back-to-back, with no bubbles.
- Priority: rule0 mask=4'b1000 value=4'b1000 code=6, rule1 mask=0 code=7; in_data=4'b1010 -> code 6, out_rule=0; in_data=4'b0010 -> code 7, out_rule=1.
- Back-pressure: hold out_ready=0 for 3 cycles -> in_ready=0, out_code stable; release -> next word accepted the same cycle.
- Write/accept collision: rewrite rule0 code 1->2 in the same cycle as accepting a rule-0 word -> that word gets 1, the next gets 2.
- With PATTERN_CLASSIFIER_HIT_CNT_EN and CNT_W=4: 20 hits on rule2 -> cnt_data=15 (saturated); miss counter counts defaults; cnt_clr together with a hit -> 0 next cycle.
